// File: rtl/finc_fdec_if.sv
// Request/status bundle between the clock controller and one FINC/FDEC sequencer.
// The controller side is master; the sequencer side is slave.
interface finc_fdec_if #(
  parameter int unsigned PENDING_W = 8
) ();
  logic                 req_valid;
  logic [1:0]           req_speed;
  logic                 clear_overflow;
  logic                 FINC;
  logic                 FDEC;
  logic                 busy;
  logic [PENDING_W-1:0] pending;
  logic                 overflow;

  modport master (
    output req_valid, req_speed, clear_overflow,
    input  FINC, FDEC, busy, pending, overflow
  );

  modport slave (
    input  req_valid, req_speed, clear_overflow,
    output FINC, FDEC, busy, pending, overflow
  );
endinterface

// File: rtl/finc_fdec_sequencer.sv
// Turns speed-change requests into spaced FINC/FDEC pulses for the clock generator.
// Requests arriving during a pulse are accumulated as a saturating signed net step count.
module finc_fdec_sequencer #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter int unsigned PENDING_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  finc_fdec_if.slave  bus
);

  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SUM_W   = PENDING_W + 1;

  localparam logic signed [SUM_W-1:0] POS_LIM = $signed({2'b00, {(PENDING_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] NEG_LIM = -POS_LIM;
  localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          finc_q, finc_d;
  logic                          fdec_q, fdec_d;
  logic                          busy_q, busy_d;
  logic signed [PENDING_W-1:0]   pend_q, pend_d;
  logic                          ovf_q, ovf_d;

  logic signed [SUM_W-1:0]       issue_delta;
  logic signed [SUM_W-1:0]       req_delta;
  logic signed [SUM_W-1:0]       base;
  logic signed [SUM_W-1:0]       sum;
  logic                          drop;

  // State and output registers; async reset drops the pins immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      finc_q  <= 1'b0;
      fdec_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      finc_q  <= finc_d;
      fdec_q  <= fdec_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, pin and accumulator logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    finc_d      = finc_q;
    fdec_d      = fdec_q;
    issue_delta = '0;
    req_delta   = '0;
    drop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          if (!pend_q[PENDING_W-1]) begin
            finc_d      = 1'b1;
            issue_delta = -ONE;
          end else begin
            fdec_d      = 1'b1;
            issue_delta = ONE;
          end
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          finc_d  = 1'b0;
          fdec_d  = 1'b0;
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        finc_d  = 1'b0;
        fdec_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);

    if (bus.req_valid) begin
      case (bus.req_speed)
        2'b10:   req_delta = ONE;
        2'b01:   req_delta = -ONE;
        default: req_delta = '0;
      endcase
    end

    // Issuing always moves toward zero, so only the request can push past a bound
    base = {pend_q[PENDING_W-1], pend_q} + issue_delta;
    sum  = base + req_delta;
    if ((sum > POS_LIM) || (sum < NEG_LIM)) begin
      drop   = 1'b1;
      pend_d = base[PENDING_W-1:0];
    end else begin
      pend_d = sum[PENDING_W-1:0];
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign bus.FINC     = finc_q;
  assign bus.FDEC     = fdec_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_finc_fdec_sequencer.sv
// Bench for finc_fdec_sequencer: directed and random requests compared every cycle
// against a timeline model (pulse start edge, busy-until edge, integer pending count).
module tb_finc_fdec_sequencer;

  localparam int P   = 4;
  localparam int G   = 8;
  localparam int PW  = 8;
  localparam int MAXV = (1 << (PW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  finc_fdec_if #(.PENDING_W(PW)) bus ();

  finc_fdec_sequencer #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .PENDING_W    (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: edge counter, signed pending, current pulse start/direction, first idle edge
  int n          = 0;
  int pend_m     = 0;
  int start      = -1000;
  int dir        = 0;
  int busy_until = 0;
  bit ovf_m      = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, expv, n);
    end
  endtask

  task automatic check_all();
    int ef;
    int ed;
    int eb;
    ef = (dir > 0 && n >= start && n < start + P) ? 1 : 0;
    ed = (dir < 0 && n >= start && n < start + P) ? 1 : 0;
    eb = (n >= start && n < busy_until) ? 1 : 0;
    chk("FINC", int'(bus.FINC), ef);
    chk("FDEC", int'(bus.FDEC), ed);
    chk("busy", int'(bus.busy), eb);
    chk("pending", int'($signed(bus.pending)), pend_m);
    chk("overflow", int'(bus.overflow), int'(ovf_m));
    chk("exclusive", int'(bus.FINC & bus.FDEC), 0);
  endtask

  task automatic step(input bit rv, input logic [1:0] rs, input bit co);
    int issue;
    int req;
    int sum;
    bit drop;
    bus.req_valid      = rv;
    bus.req_speed      = rs;
    bus.clear_overflow = co;
    @(posedge clk);
    n++;
    issue = 0;
    if (n > busy_until && pend_m != 0) begin
      dir        = (pend_m > 0) ? 1 : -1;
      start      = n;
      busy_until = n + P + G;
      issue      = -dir;
    end
    req = 0;
    if (rv && rs == 2'b10) req = 1;
    if (rv && rs == 2'b01) req = -1;
    sum  = pend_m + issue + req;
    drop = 1'b0;
    if (sum > MAXV || sum < -MAXV) begin
      drop = 1'b1;
      sum  = pend_m + issue;
    end
    pend_m = sum;
    if (drop) ovf_m = 1'b1;
    else if (co) ovf_m = 1'b0;
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_FINC", int'(bus.FINC), 0);
    chk("rst_FDEC", int'(bus.FDEC), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pending", int'($signed(bus.pending)), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    repeat (2) @(posedge clk);
    #2;
    rst        = 1'b0;
    pend_m     = 0;
    ovf_m      = 1'b0;
    dir        = 0;
    start      = -1000;
    busy_until = n;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_speed      = 2'b00;
    bus.clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all();

    idle(10);

    // single speed-up
    step(1'b1, 2'b10, 1'b0);
    idle(20);

    // five consecutive slow-downs
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0);
    idle(70);

    // speed up then slow down back to back
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    idle(40);

    // saturation, recovery, clear, and set-wins-over-clear
    for (int i = 0; i < 145; i++) step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1);
    idle(5);

    // reset two cycles into an FINC pulse
    async_reset();
    idle(3);
    step(1'b1, 2'b10, 1'b0);
    idle(2);
    async_reset();
    idle(30);

    // ignored request codes
    step(1'b1, 2'b11, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b01, 1'b0);
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit rv;
      logic [1:0] rs;
      bit co;
      rv = ($urandom_range(0, 7) < 3);
      rs = 2'($urandom_range(0, 3));
      co = ($urandom_range(0, 15) == 0);
      step(rv, rs, co);
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
